// File: rtl/switch_mcu_decode_stage.sv
// rtl/switch_mcu_decode_stage.sv - RV32I(+M,+Zicsr) decode stage with 2-entry skid buffer
module switch_mcu_decode_stage #(
    parameter bit ENABLE_M   = 1'b1,
    parameter bit ENABLE_CSR = 1'b1,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 input_clk,
    input  logic                 input_rst,
    input  logic                 input_flush,
    input  logic                 input_inst_valid,
    input  logic [31:0]          input_inst,
    input  logic [PC_WIDTH-1:0]  input_pc,
    output logic                 output_inst_ready,
    output logic                 output_valid,
    input  logic                 input_ready,
    output logic [5:0]           output_op,
    output logic [4:0]           output_rd,
    output logic [4:0]           output_rs1,
    output logic [4:0]           output_rs2,
    output logic [31:0]          output_imm,
    output logic                 output_illegal,
    output logic [PC_WIDTH-1:0]  output_pc,
    output logic [CNT_WIDTH-1:0] output_illegal_count
);

    // Entry layout: {op, rd, rs1, rs2, imm, illegal, pc}
    localparam int EW = 6 + 5 + 5 + 5 + 32 + 1 + PC_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Immediate format selector
    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_J     = 3'd4,
        IMM_U     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_sel_t;

    logic [6:0]     w_opcode;
    logic [2:0]     w_funct3;
    logic [6:0]     w_funct7;
    logic [4:0]     w_rd;
    logic [4:0]     w_rs1;
    logic [4:0]     w_rs2;
    logic [5:0]     w_op;
    logic [31:0]    w_imm;
    logic           w_illegal;
    imm_sel_t       w_imm_sel;
    logic [EW-1:0]  w_dec_entry;
    logic           w_accept;
    logic           w_drain;
    logic           w_main_free;

    logic [EW-1:0]          r_main;
    logic                   r_main_valid;
    logic [EW-1:0]          r_skid;
    logic                   r_skid_valid;
    logic [CNT_WIDTH-1:0]   r_illegal_count;

    assign w_opcode = input_inst[6:0];
    assign w_funct3 = input_inst[14:12];
    assign w_funct7 = input_inst[31:25];
    assign w_rd     = input_inst[11:7];
    assign w_rs1    = input_inst[19:15];
    assign w_rs2    = input_inst[24:20];

    // Classify the presented instruction into an op code and immediate format
    always_comb begin
        w_op      = 6'd0;
        w_imm_sel = IMM_NONE;
        case (w_opcode)
            7'b0110111: begin w_op = 6'd1; w_imm_sel = IMM_U; end
            7'b0010111: begin w_op = 6'd2; w_imm_sel = IMM_U; end
            7'b1101111: begin w_op = 6'd3; w_imm_sel = IMM_J; end
            7'b1100111: begin
                w_imm_sel = IMM_I;
                if (w_funct3 == 3'b000) w_op = 6'd4;
            end
            7'b1100011: begin
                w_imm_sel = IMM_B;
                case (w_funct3)
                    3'b000:  w_op = 6'd5;
                    3'b001:  w_op = 6'd6;
                    3'b100:  w_op = 6'd7;
                    3'b101:  w_op = 6'd8;
                    3'b110:  w_op = 6'd9;
                    3'b111:  w_op = 6'd10;
                    default: w_op = 6'd0;
                endcase
            end
            7'b0000011: begin
                w_imm_sel = IMM_I;
                case (w_funct3)
                    3'b000:  w_op = 6'd11;
                    3'b001:  w_op = 6'd12;
                    3'b010:  w_op = 6'd13;
                    3'b100:  w_op = 6'd14;
                    3'b101:  w_op = 6'd15;
                    default: w_op = 6'd0;
                endcase
            end
            7'b0100011: begin
                w_imm_sel = IMM_S;
                case (w_funct3)
                    3'b000:  w_op = 6'd16;
                    3'b001:  w_op = 6'd17;
                    3'b010:  w_op = 6'd18;
                    default: w_op = 6'd0;
                endcase
            end
            7'b0010011: begin
                w_imm_sel = IMM_I;
                case (w_funct3)
                    3'b000: w_op = 6'd19;
                    3'b010: w_op = 6'd20;
                    3'b011: w_op = 6'd21;
                    3'b100: w_op = 6'd22;
                    3'b110: w_op = 6'd23;
                    3'b111: w_op = 6'd24;
                    3'b001: begin
                        w_imm_sel = IMM_SHAMT;
                        if (w_funct7 == 7'b0000000) w_op = 6'd25;
                    end
                    default: begin
                        w_imm_sel = IMM_SHAMT;
                        if (w_funct7 == 7'b0000000)      w_op = 6'd26;
                        else if (w_funct7 == 7'b0100000) w_op = 6'd27;
                    end
                endcase
            end
            7'b0110011: begin
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000: w_op = 6'd28;
                        3'b001: w_op = 6'd30;
                        3'b010: w_op = 6'd31;
                        3'b011: w_op = 6'd32;
                        3'b100: w_op = 6'd33;
                        3'b101: w_op = 6'd34;
                        3'b110: w_op = 6'd36;
                        default: w_op = 6'd37;
                    endcase
                end else if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000)      w_op = 6'd29;
                    else if (w_funct3 == 3'b101) w_op = 6'd35;
                end else if (w_funct7 == 7'b0000001 && ENABLE_M) begin
                    w_op = 6'd48 + {3'b000, w_funct3};
                end
            end
            7'b0001111: begin
                if (input_inst == 32'h0000_100F) begin
                    w_op = 6'd39;
                end else if (input_inst[31:28] == 4'd0 && w_rs1 == 5'd0 &&
                             w_rd == 5'd0 && w_funct3 == 3'b000) begin
                    w_op = 6'd38;
                end
            end
            7'b1110011: begin
                if (input_inst == 32'h0000_0073) begin
                    w_op = 6'd40;
                end else if (input_inst == 32'h0010_0073) begin
                    w_op = 6'd41;
                end else if (ENABLE_CSR) begin
                    w_imm_sel = IMM_I;
                    case (w_funct3)
                        3'b001:  w_op = 6'd42;
                        3'b010:  w_op = 6'd43;
                        3'b011:  w_op = 6'd44;
                        3'b101:  w_op = 6'd45;
                        3'b110:  w_op = 6'd46;
                        3'b111:  w_op = 6'd47;
                        default: w_op = 6'd0;
                    endcase
                end
            end
            default: w_op = 6'd0;
        endcase
    end

    assign w_illegal = (w_op == 6'd0);

    // Build the immediate; illegal entries always carry zero
    always_comb begin
        w_imm = 32'd0;
        if (!w_illegal) begin
            case (w_imm_sel)
                IMM_I:     w_imm = {{20{input_inst[31]}}, input_inst[31:20]};
                IMM_S:     w_imm = {{20{input_inst[31]}}, input_inst[31:25], input_inst[11:7]};
                IMM_B:     w_imm = {{19{input_inst[31]}}, input_inst[31], input_inst[7],
                                    input_inst[30:25], input_inst[11:8], 1'b0};
                IMM_J:     w_imm = {{11{input_inst[31]}}, input_inst[31], input_inst[19:12],
                                    input_inst[20], input_inst[30:21], 1'b0};
                IMM_U:     w_imm = {input_inst[31:12], 12'd0};
                IMM_SHAMT: w_imm = {27'd0, input_inst[24:20]};
                default:   w_imm = 32'd0;
            endcase
        end
    end

    assign w_dec_entry = {w_op, w_rd, w_rs1, w_rs2, w_imm, w_illegal, input_pc};

    // Flush suppresses the same-cycle accept so a dropped input is never counted
    assign w_accept    = input_inst_valid & output_inst_ready & ~input_flush;
    assign w_drain     = r_main_valid & input_ready;
    assign w_main_free = ~r_main_valid | w_drain;

    // Skid buffer: main refills from skid first to keep order, else from the decoder
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (input_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_dec_entry;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec_entry;
            r_skid_valid <= 1'b1;
        end
    end

    // Count illegal instructions at accept time, saturating at all-ones
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            r_illegal_count <= '0;
        end else if (w_accept && w_illegal && (r_illegal_count != {CNT_WIDTH{1'b1}})) begin
            r_illegal_count <= r_illegal_count + CNT_ONE;
        end
    end

    assign output_inst_ready    = ~r_skid_valid;
    assign output_valid         = r_main_valid;
    assign output_illegal_count = r_illegal_count;

    assign output_op      = r_main[EW-1 -: 6];
    assign output_rd      = r_main[EW-7 -: 5];
    assign output_rs1     = r_main[EW-12 -: 5];
    assign output_rs2     = r_main[EW-17 -: 5];
    assign output_imm     = r_main[PC_WIDTH+32 -: 32];
    assign output_illegal = r_main[PC_WIDTH];
    assign output_pc      = r_main[PC_WIDTH-1:0];

endmodule

// File: tb/tb_switch_mcu_decode_stage.sv
// tb/tb_switch_mcu_decode_stage.sv - directed self-checking bench for switch_mcu_decode_stage
module tb_switch_mcu_decode_stage;

    logic        clk;
    logic        rst;

    logic        a_flush, a_valid, a_ready;
    logic [31:0] a_inst, a_pc;
    logic        a_inst_ready, a_out_valid, a_illegal;
    logic [5:0]  a_op;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [31:0] a_imm, a_out_pc;
    logic [15:0] a_count;

    logic        b_flush, b_valid, b_ready;
    logic [31:0] b_inst, b_pc;
    logic        b_inst_ready, b_out_valid, b_illegal;
    logic [5:0]  b_op;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [31:0] b_imm, b_out_pc;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    switch_mcu_decode_stage dut_a (
        .input_clk(clk), .input_rst(rst), .input_flush(a_flush),
        .input_inst_valid(a_valid), .input_inst(a_inst), .input_pc(a_pc),
        .output_inst_ready(a_inst_ready), .output_valid(a_out_valid), .input_ready(a_ready),
        .output_op(a_op), .output_rd(a_rd), .output_rs1(a_rs1), .output_rs2(a_rs2),
        .output_imm(a_imm), .output_illegal(a_illegal), .output_pc(a_out_pc),
        .output_illegal_count(a_count)
    );

    switch_mcu_decode_stage #(
        .ENABLE_M(1'b0), .ENABLE_CSR(1'b0), .PC_WIDTH(32), .CNT_WIDTH(2)
    ) dut_b (
        .input_clk(clk), .input_rst(rst), .input_flush(b_flush),
        .input_inst_valid(b_valid), .input_inst(b_inst), .input_pc(b_pc),
        .output_inst_ready(b_inst_ready), .output_valid(b_out_valid), .input_ready(b_ready),
        .output_op(b_op), .output_rd(b_rd), .output_rs1(b_rs1), .output_rs2(b_rs2),
        .output_imm(b_imm), .output_illegal(b_illegal), .output_pc(b_out_pc),
        .output_illegal_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        a_valid = v;
        a_inst  = inst;
        a_pc    = pc;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] inst);
        b_valid = v;
        b_inst  = inst;
        b_pc    = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_valid = 1'b0; a_ready = 1'b1; a_inst = '0; a_pc = '0;
        b_flush = 1'b0; b_valid = 1'b0; b_ready = 1'b1; b_inst = '0; b_pc = '0;
        step();
        step();

        check("rst_valid",   a_out_valid, 0);
        check("rst_iready",  a_inst_ready, 1);
        check("rst_count",   a_count, 0);
        check("rst_op",      a_op, 0);
        check("rst_imm",     a_imm, 0);
        check("rst_regs",    {a_rd, a_rs1, a_rs2}, 0);
        check("rst_pc",      a_out_pc, 0);
        check("rst_illegal", a_illegal, 0);
        rst = 1'b0;

        // addi x1,x0,5
        drive_a(1, 32'h0050_0093, 32'h100);
        step();
        drive_a(0, 0, 0);
        check("addi_valid", a_out_valid, 1);
        check("addi_op",    a_op, 19);
        check("addi_rd",    a_rd, 1);
        check("addi_rs1",   a_rs1, 0);
        check("addi_imm",   a_imm, 5);
        check("addi_ill",   a_illegal, 0);
        check("addi_pc",    a_out_pc, 32'h100);

        // back-to-back: sub, beq -4, ebreak
        drive_a(1, 32'h4020_81B3, 32'h104);
        step();
        check("sub_op",  a_op, 29);
        check("sub_rd",  a_rd, 3);
        check("sub_rs2", a_rs2, 2);
        drive_a(1, 32'hFE00_0EE3, 32'h108);
        step();
        check("beq_op",  a_op, 5);
        check("beq_imm", a_imm, 32'hFFFF_FFFC);
        check("beq_pc",  a_out_pc, 32'h108);
        drive_a(1, 32'h0010_0073, 32'h10C);
        step();
        check("ebreak_op",  a_op, 41);
        check("ebreak_imm", a_imm, 0);
        drive_a(1, 32'h027302B3, 32'h110);
        step();
        check("mul_op", a_op, 48);
        check("mul_rd", a_rd, 5);
        drive_a(1, 32'h1234_50B7, 32'h114);
        step();
        check("lui_op",  a_op, 1);
        check("lui_imm", a_imm, 32'h1234_5000);
        drive_a(1, 32'h3000_22F3, 32'h118);
        step();
        check("csrrs_op",  a_op, 43);
        check("csrrs_imm", a_imm, 32'h300);
        drive_a(1, 32'h4050_5093, 32'h11C);
        step();
        check("srai_op",  a_op, 27);
        check("srai_imm", a_imm, 5);
        drive_a(0, 0, 0);
        step();
        check("idle_valid", a_out_valid, 0);
        check("a_count_legal", a_count, 0);

        // backpressure: three presented while downstream stalls
        a_ready = 1'b0;
        drive_a(1, 32'h0050_0093, 32'h1);
        step();
        check("bp1_iready", a_inst_ready, 1);
        check("bp1_pc",     a_out_pc, 32'h1);
        drive_a(1, 32'h00A0_0113, 32'h2);
        step();
        check("bp2_iready", a_inst_ready, 0);
        check("bp2_pc",     a_out_pc, 32'h1);
        drive_a(1, 32'h0030_0193, 32'h3);
        step();
        check("bp3_iready", a_inst_ready, 0);
        check("bp3_pc",     a_out_pc, 32'h1);
        a_ready = 1'b1;
        step();
        check("rel1_pc",     a_out_pc, 32'h2);
        check("rel1_rd",     a_rd, 2);
        check("rel1_iready", a_inst_ready, 1);
        step();
        check("rel2_pc",    a_out_pc, 32'h3);
        check("rel2_valid", a_out_valid, 1);
        drive_a(0, 0, 0);
        step();
        check("rel3_valid", a_out_valid, 0);

        // flush with both entries full and an illegal input presented
        a_ready = 1'b0;
        drive_a(1, 32'h0050_0093, 32'h10);
        step();
        drive_a(1, 32'h00A0_0113, 32'h11);
        step();
        check("fl_full", a_inst_ready, 0);
        drive_a(1, 32'h0000_0000, 32'h12);
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        drive_a(0, 0, 0);
        check("fl_valid",  a_out_valid, 0);
        check("fl_iready", a_inst_ready, 1);
        check("fl_count",  a_count, 0);
        a_ready = 1'b1;
        step();
        check("fl_after_valid", a_out_valid, 0);

        // no-M / no-CSR instance with 2-bit counter
        drive_b(1, 32'h0273_02B3);
        step();
        check("nm_mul_op",  b_op, 0);
        check("nm_mul_ill", b_illegal, 1);
        check("nm_mul_imm", b_imm, 0);
        check("nm_cnt1",    b_count, 1);
        drive_b(1, 32'h0020_0073);
        step();
        check("nm_sys_ill", b_illegal, 1);
        check("nm_cnt2",    b_count, 2);
        drive_b(1, 32'h0000_0073);
        step();
        check("nm_ecall_op", b_op, 40);
        check("nm_cnt_hold", b_count, 2);
        drive_b(1, 32'h3052_9073);
        step();
        check("nm_csr_ill", b_illegal, 1);
        check("nm_cnt3",    b_count, 3);
        drive_b(1, 32'hFFFF_FFFF);
        step();
        drive_b(1, 32'h0000_0000);
        step();
        check("nm_sat", b_count, 3);
        drive_b(0, 0);
        step();
        check("nm_idle", b_out_valid, 0);

        // reset mid-stream discards buffered entries
        a_ready = 1'b0;
        drive_a(1, 32'h0050_0093, 32'h20);
        step();
        step();
        check("mr_full", a_inst_ready, 0);
        drive_a(0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_valid",  a_out_valid, 0);
        check("mr_iready", a_inst_ready, 1);
        check("mr_bcount", b_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
